fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO, successor to the fixed 8x16 FIFO, used as the standard single-clock buffer between producer and consumer stages. It adds configurable width and depth, a selectable read mode (registered or first-word fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Storage is an inferred register array indexed by wrap-bit pointers.

## Interface
- DATA_W, 8: data width in bits, >= 1
- DEPTH, 16: entries; power of 2, >= 2
- AFULL_TH, DEPTH-4: almost_full asserts when level >= AFULL_TH; range 1..DEPTH
- AEMPTY_TH, 2: almost_empty asserts when level <= AEMPTY_TH; range 0..DEPTH-1
- FWFT, 0: 0 = registered read mode; 1 = first-word fall-through mode
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of head word)
- err_clr  in  1  synchronous clear of overflow/underflow
- dout  out  DATA_W  read data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AFULL_TH
- almost_empty  out  1  level <= AEMPTY_TH
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- Pointers w_ptr, r_ptr: $clog2(DEPTH)+1 bits. Low bits index the array; the MSB is the wrap bit. Pointers increment by 1 and wrap modulo 2*DEPTH naturally.
- empty = (w_ptr == r_ptr). full = low bits equal and MSBs differ. level = w_ptr - r_ptr, computed modulo 2*DEPTH.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wr_acc = wr_en && (!full || rd_acc). A simultaneous read frees the slot, so a write on full is accepted together with a read.
- On an empty FIFO with wr_en && rd_en: the write is accepted, the read is rejected, and underflow is set.
- wr_acc: mem[w_ptr low] <= din; w_ptr += 1. rd_acc: r_ptr += 1.
- Registered mode (FWFT=0): on rd_acc, dout <= mem[r_ptr low]; otherwise dout holds its value.
- FWFT mode: dout = empty ? 0 : mem[r_ptr low], combinational from registered state. The head word is visible without a request; rd_acc consumes it.
- overflow sets on wr_en && !wr_acc. underflow sets on rd_en && empty.
- err_clr clears both error flags. If a set and err_clr occur in the same cycle, the set wins.
- Rejected operations change no pointer, no memory location, and no dout.
- Reset (asynchronous, any time, including mid-burst): w_ptr = r_ptr = 0, dout = 0, overflow = underflow = 0.
  - Resulting outputs: empty=1, full=0, level=0, almost_empty=1, almost_full=0 (given AFULL_TH >= 1).
  - Memory contents are not cleared.

## Timing
- All flags and level derive from registered pointers. They update in the cycle after the accepting edge, with no combinational path from wr_en/rd_en.
- Write-to-visible latency:
  - empty deasserts 1 cycle after the write edge.
  - FWFT: dout shows the word 1 cycle after the write edge.
  - Registered mode: the word appears on dout 1 cycle after the rd_acc edge.
- Throughput: one write and one read per cycle, sustained, in any fill state.
- Simultaneous wr_acc && rd_acc: level unchanged, full/empty unchanged.
- Error flags assert the cycle after the offending edge.

## Test plan
- Reset, then write 0x01..0x10 (DATA_W=8, DEPTH=16, FWFT=0), then read 16 -> dout sequence 0x01..0x10, each one cycle after rd_en. level goes 16 then 0. full=1 after the 16th write; empty=1 after the 16th read.
- Full FIFO plus a 17th write alone -> overflow=1, level stays 16, data unchanged. Then err_clr=1 -> overflow=0 next cycle. Then read on empty -> underflow=1.
- Full FIFO with wr_en=rd_en=1 for 5 cycles -> full stays 1, level 16. Read-out order has the 5 new words after the original 16, with no loss.
- Thresholds (AFULL_TH=12, AEMPTY_TH=2): fill one per cycle -> almost_empty drops at level 3, almost_full rises at level 12. Drain -> the reverse transitions occur at the same levels.
- FWFT=1: write 0xA5 to an empty FIFO -> dout=0xA5 and empty=0 next cycle, with no rd_en. Pop -> dout=0, empty=1.
- Fill to 10 and run 40 cycles of concurrent writes/reads to force pointer wrap. Assert reset mid-stream -> level=0, empty=1, dout=0 immediately. Post-reset writes read back correctly.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param. The master side drives requests and
// the slave side (the FIFO) returns data, flags, occupancy and sticky errors.
interface fifo_sync_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en, err_clr,
        input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, err_clr,
        output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with level, thresholds, sticky errors, registered or FWFT read.
// Latency: flags/level 1 cycle after the accepting edge; dout 1 cycle after write (FWFT) or rd_acc (registered).
// Backpressure: writes on full rejected unless paired with a read; reads on empty rejected; both raise sticky errors.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic               clk,
    input  logic               reset,
    fifo_sync_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     w_ptr_q, w_ptr_d;
    logic [PW-1:0]     r_ptr_q, r_ptr_d;
    logic [PW-1:0]     level;
    logic [AW-1:0]     w_idx, r_idx;
    logic              empty, full;
    logic              rd_acc, wr_acc;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    always_comb begin
        w_idx  = w_ptr_q[AW-1:0];
        r_idx  = r_ptr_q[AW-1:0];
        empty  = (w_ptr_q == r_ptr_q);
        full   = (w_idx == r_idx) && (w_ptr_q[AW] != r_ptr_q[AW]);
        level  = w_ptr_q - r_ptr_q;
        rd_acc = bus.rd_en && !empty;
        wr_acc = bus.wr_en && (!full || rd_acc);
    end

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        if (wr_acc) w_ptr_d = w_ptr_q + PW'(1);
        if (rd_acc) r_ptr_d = r_ptr_q + PW'(1);
        // Setting wins over a same-cycle clear.
        overflow_d  = (bus.wr_en && !wr_acc) || (overflow_q && !bus.err_clr);
        underflow_d = (bus.rd_en && empty) || (underflow_q && !bus.err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[w_idx] <= bus.din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout = empty ? '0 : mem_q[r_idx];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       dout_q <= '0;
                else if (rd_acc) dout_q <= mem_q[r_idx];
            end
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.level        = level;
    assign bus.almost_full  = (level >= AFULL_LVL);
    assign bus.almost_empty = (level <= AEMPTY_LVL);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives identical traffic into a registered-read and an FWFT instance and scores both against one model.
module tb_fifo_sync_param;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AF = 12;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_reg ();
    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DP)) bus_fw ();

    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) dut_reg (
        .clk(clk), .reset(reset), .bus(bus_reg)
    );
    fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) dut_fw (
        .clk(clk), .reset(reset), .bus(bus_fw)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  sb [$];
    int          lvl;
    bit          ovf, udf;
    logic [7:0]  dout_reg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bus_reg.wr_en = wr; bus_reg.din = d; bus_reg.rd_en = rd; bus_reg.err_clr = clr;
        bus_fw.wr_en  = wr; bus_fw.din  = d; bus_fw.rd_en  = rd; bus_fw.err_clr  = clr;
    endtask

    task automatic check_all();
        logic [7:0] head;
        head = (sb.size() > 0) ? sb[0] : 8'h00;
        check("reg.level",  32'(bus_reg.level),        32'(lvl));
        check("reg.empty",  32'(bus_reg.empty),        32'(lvl == 0));
        check("reg.full",   32'(bus_reg.full),         32'(lvl == DP));
        check("reg.afull",  32'(bus_reg.almost_full),  32'(lvl >= AF));
        check("reg.aempty", 32'(bus_reg.almost_empty), 32'(lvl <= AE));
        check("reg.ovf",    32'(bus_reg.overflow),     32'(ovf));
        check("reg.udf",    32'(bus_reg.underflow),    32'(udf));
        check("reg.dout",   32'(bus_reg.dout),         32'(dout_reg));
        check("fw.level",   32'(bus_fw.level),         32'(lvl));
        check("fw.empty",   32'(bus_fw.empty),         32'(lvl == 0));
        check("fw.full",    32'(bus_fw.full),          32'(lvl == DP));
        check("fw.afull",   32'(bus_fw.almost_full),   32'(lvl >= AF));
        check("fw.aempty",  32'(bus_fw.almost_empty),  32'(lvl <= AE));
        check("fw.ovf",     32'(bus_fw.overflow),      32'(ovf));
        check("fw.udf",     32'(bus_fw.underflow),     32'(udf));
        check("fw.dout",    32'(bus_fw.dout),          32'(head));
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit ra, wa;
        ra = rd && (lvl > 0);
        wa = wr && ((lvl < DP) || ra);
        if (wr && !wa) ovf = 1'b1; else if (clr) ovf = 1'b0;
        if (rd && lvl == 0) udf = 1'b1; else if (clr) udf = 1'b0;
        if (ra) dout_reg = sb.pop_front();
        if (wa) sb.push_back(d);
        lvl = lvl + int'(wa) - int'(ra);
        drive(wr, d, rd, clr);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_all();
    endtask

    task automatic model_reset();
        sb.delete();
        lvl = 0; ovf = 1'b0; udf = 1'b0; dout_reg = 8'h00;
    endtask

    initial begin
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        reset = 1'b1;
        #12;
        check_all();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill 0x01..0x10, then a rejected 17th write.
        for (int i = 1; i <= DP; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        // Rejected write together with err_clr: the set must win.
        cyc(1'b1, 8'hEF, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with concurrent write and read: level holds, no loss.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);

        // Drain everything, then read on empty.
        for (int i = 0; i < DP; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Empty with write and read: write taken, read rejected.
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);

        // Head fall-through on the FWFT instance, then pop.
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to 10 and stream concurrently so both pointers wrap.
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

        // Asynchronous reset in the middle of traffic.
        if (lvl == 0) cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all();

        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
